nib_track_writeback: RTL and testbench
======================================

// Module: nib_track_writeback
//
// PURPOSE
// Write-back side of the NIB floppy path: flushes the 6656-byte track buffer
// (13 x 512-byte SD sectors) to the mounted image via hps_io sd_wr/sd_ack.
// Sits beside the track loader in emu. It tracks a dirty flag from disk
// controller writes. It holds off the loader and the CPU while it flushes
// the old track, before a new track is fetched, on flush_req, or after an
// idle timeout.
//
// PARAMETERS
// SECTORS       13        SD sectors per track; LBA base = SECTORS*track
// IDLE_TIMEOUT  2800000   clk_sys cycles after last disk_we before auto-flush (0 = off)
//
// PORTS
// clk_sys       in   1   system clock (14 MHz)
// reset         in   1   asynchronous, active-high
// img_mounted   in   1   pulse: new image mounted; clears dirty
// img_readonly  in   1   1 = image not writable; dirty never set
// img_present   in   1   img_size != 0
// cur_track     in   6   track currently held in track RAM (loader side)
// track_req     in   6   track requested by disk controller
// disk_we       in   1   controller write strobe into track RAM
// flush_req     in   1   pulse: flush now if dirty (e.g. motor off)
// sd_lba        out  32  sector address to hps_io
// sd_wr         out  1   write request to hps_io
// sd_ack        in   1   hps_io sector transfer active
// sd_buff_addr  in   9   byte index within current sector
// sd_buff_din   out  8   byte to hps_io; = tram_dout
// tram_addr     out  13  track RAM read address = {sec[3:0], sd_buff_addr}
// tram_dout     in   8   track RAM read data, 1-cycle registered latency
// load_hold     out  1   loader must not start a new track fetch
// cpu_wait      out  1   stall CPU during flush
// busy          out  1   state != IDLE
//
// BEHAVIOUR
// - Reset: state=IDLE, dirty=0, sec=0, sd_lba=0, sd_wr=0, cpu_wait=0, idle_cnt=0.
// - dirty: set on disk_we when img_present & ~img_readonly. Cleared on
//   img_mounted, which has priority over disk_we in the same cycle.
//   Cleared on the flush start cycle. disk_we on that same cycle re-sets it.
// - load_hold = busy | (dirty & (track_req != cur_track)). It is combinational,
//   so the loader sees it the cycle the mismatch appears.
// - Start (IDLE only): dirty & img_present & (track_req!=cur_track | flush_req |
//   idle_cnt==IDLE_TIMEOUT). On start: wb_track<=cur_track, sec<=0,
//   sd_lba<=SECTORS*cur_track (32-bit), sd_wr<=1, cpu_wait<=1, state<=XFER.
// - idle_cnt: cleared by disk_we and by start. Otherwise counts up while dirty
//   and saturates at IDLE_TIMEOUT. Held at 0 when IDLE_TIMEOUT=0.
// - XFER, on sd_ack rise: sd_lba<=sd_lba+1. If sec>=SECTORS-1, sd_wr<=0.
// - XFER, on sd_ack fall: sec<=sec+1. If sd_wr==0, state<=IDLE and cpu_wait<=0.
// - sd_ack edges come from a registered copy of sd_ack.
// - tram_addr tracks sd_buff_addr combinationally. sd_buff_din=tram_dout.
//   hps_io's 1-cycle sampling matches the RAM latency.
// - img_mounted during XFER: sd_wr<=0 at once. Stay in XFER until the next
//   sd_ack fall, or go straight to IDLE if sd_ack is low. dirty stays 0.
// - img_present low during XFER: handled the same as img_mounted.
// - Reset mid-flush: return to IDLE at once, drop sd_wr. The partial track
//   is lost. This is accepted.
// - The track_req change is ignored while busy. It is re-evaluated in IDLE,
//   and dirty is 0 by then, so there is no second flush.
//
// TESTING
// 1 disk_we x1 on track 5, then track_req 5->6: load_hold=1 same cycle;
//   sd_lba=65..77, 13 ack pulses, cpu_wait 1->0, then load_hold=0.
// 2 Byte check: preload tram {sec,addr}=sec^addr. Capture sd_buff_din at each
//   sd_buff_addr step. All 6656 bytes match, first byte lands on addr 0.
// 3 img_readonly=1 with disk_we, then track change: no sd_wr, load_hold stays 0.
// 4 IDLE_TIMEOUT=100, one disk_we, no activity: flush starts on cycle 101
//   after the write. A disk_we at cycle 50 delays the start to cycle 151.
// 5 img_mounted at sector 4 ack high: sd_wr drops, no sector-5 request,
//   IDLE after the ack fall, dirty=0.
// 6 Reset asserted mid-sector 7: all outputs return to reset values
//   asynchronously. A new disk_we plus flush_req restarts at sector 0.

Source files
------------

// File: rtl/nib_track_writeback_if.sv
// SD write-back bus between the track flusher and hps_io / track RAM.
// master: flusher (lba, wr, din, tram_addr out); slave: hps_io + track RAM.
interface nib_track_writeback_if;
  logic [31:0] sd_lba;
  logic        sd_wr;
  logic        sd_ack;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_din;
  logic [12:0] tram_addr;
  logic [7:0]  tram_dout;

  modport master (
    output sd_lba,
    output sd_wr,
    output sd_buff_din,
    output tram_addr,
    input  sd_ack,
    input  sd_buff_addr,
    input  tram_dout
  );

  modport slave (
    input  sd_lba,
    input  sd_wr,
    input  sd_buff_din,
    input  tram_addr,
    output sd_ack,
    output sd_buff_addr,
    output tram_dout
  );
endinterface

// File: rtl/nib_track_writeback.sv
// NIB track write-back: flushes a dirty 13-sector track buffer to the SD image.
// Ports: clk_sys/reset, image status, track numbers, disk_we, flush_req,
// sd bus (interface master), load_hold, cpu_wait, busy.
module nib_track_writeback #(
  parameter int SECTORS      = 13,
  parameter int IDLE_TIMEOUT = 2800000
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       img_mounted,
  input  logic       img_readonly,
  input  logic       img_present,
  input  logic [5:0] cur_track,
  input  logic [5:0] track_req,
  input  logic       disk_we,
  input  logic       flush_req,
  nib_track_writeback_if.master sd,
  output logic       load_hold,
  output logic       cpu_wait,
  output logic       busy
);

  localparam int CW =
    (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMO   = CW'(IDLE_TIMEOUT);
  localparam logic [31:0]   SEC32 = 32'(SECTORS);
  localparam logic [3:0]    LAST  = 4'(SECTORS - 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t        state_q, state_d;
  logic          dirty_q, dirty_d;
  logic [3:0]    sec_q, sec_d;
  logic [31:0]   lba_q, lba_d;
  logic          wr_q, wr_d;
  logic          wait_q, wait_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ack_q;

  logic start;
  logic we_ok;
  logic abort;
  logic rise;
  logic fall;
  logic trk_diff;
  logic tmo_hit;

  assign trk_diff = track_req != cur_track;
  assign we_ok    = disk_we & img_present & ~img_readonly;
  // Losing the image mid-flush aborts the same way as a remount.
  assign abort    = img_mounted | ~img_present;
  assign rise     = sd.sd_ack & ~ack_q;
  assign fall     = ~sd.sd_ack & ack_q;
  assign tmo_hit  = (IDLE_TIMEOUT != 0) && (cnt_q == TMO);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      dirty_q <= 1'b0;
      sec_q   <= 4'd0;
      lba_q   <= 32'd0;
      wr_q    <= 1'b0;
      wait_q  <= 1'b0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dirty_q <= dirty_d;
      sec_q   <= sec_d;
      lba_q   <= lba_d;
      wr_q    <= wr_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
      ack_q   <= sd.sd_ack;
    end
  end

  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    lba_d   = lba_q;
    wr_d    = wr_q;
    wait_d  = wait_q;
    start   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dirty_q & img_present &
            (trk_diff | flush_req | tmo_hit)) begin
          start   = 1'b1;
          state_d = XFER;
          sec_d   = 4'd0;
          lba_d   = SEC32 * 32'(cur_track);
          wr_d    = 1'b1;
          wait_d  = 1'b1;
        end
      end
      XFER: begin
        // lba runs one ahead once hps_io has latched it.
        if (rise) begin
          lba_d = lba_q + 32'd1;
          if (sec_q >= LAST) wr_d = 1'b0;
        end
        if (abort) wr_d = 1'b0;
        if (fall) sec_d = sec_q + 4'd1;
        // Finish on the ack fall after the last request, or
        // immediately on abort when no sector is in flight.
        if ((fall & ~wr_q) | (abort & ~sd.sd_ack)) begin
          state_d = IDLE;
          wait_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dirty_d = dirty_q;
    if (img_mounted)  dirty_d = 1'b0;
    else if (we_ok)   dirty_d = 1'b1;
    else if (start)   dirty_d = 1'b0;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (IDLE_TIMEOUT == 0 || disk_we || start)
      cnt_d = '0;
    else if (dirty_q && cnt_q != TMO)
      cnt_d = cnt_q + 1'b1;
  end

  assign busy           = state_q != IDLE;
  assign load_hold      = busy | (dirty_q & trk_diff);
  assign cpu_wait       = wait_q;
  assign sd.sd_lba      = lba_q;
  assign sd.sd_wr       = wr_q;
  assign sd.tram_addr   = {sec_q, sd.sd_buff_addr};
  assign sd.sd_buff_din = sd.tram_dout;

endmodule

// File: tb/tb_nib_track_writeback.sv
// Bench for nib_track_writeback: hps_io + track RAM model, directed and
// randomized flushes checked against an image-level reference.
module tb_nib_track_writeback;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic img_mounted = 1'b0;
  logic img_readonly = 1'b0;
  logic img_present = 1'b1;
  logic disk_we = 1'b0;
  logic flush_req = 1'b0;
  logic [5:0] cur_track = 6'd0;
  logic [5:0] track_req = 6'd0;
  logic load_hold, cpu_wait, busy;
  logic [7:0] mem [0:6655];
  int n_cmp = 0;
  int n_bad = 0;

  nib_track_writeback_if bus();

  nib_track_writeback #(.SECTORS(13), .IDLE_TIMEOUT(100)) dut (
    .clk_sys(clk), .reset(rst),
    .img_mounted(img_mounted), .img_readonly(img_readonly),
    .img_present(img_present),
    .cur_track(cur_track), .track_req(track_req),
    .disk_we(disk_we), .flush_req(flush_req),
    .sd(bus.master),
    .load_hold(load_hold), .cpu_wait(cpu_wait), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) bus.tram_dout <= mem[bus.tram_addr];

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input bit pat);
    for (int i = 0; i < 6656; i++)
      mem[i] = pat ? 8'((i / 512) ^ (i % 512)) : 8'($urandom);
  endtask

  // hps_io model. mode 1: remount in sector 4; mode 2: reset in sector 7.
  task automatic host(input int trk, input int mode);
    int w;
    int bad;
    int first;
    int wexp;
    w = 0;
    while (bus.sd_wr !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    chk("wr_start", bus.sd_wr, 1);
    chk("cpu_wait_on", cpu_wait, 1);
    for (int s = 0; s < 13; s++) begin
      repeat ($urandom_range(0, 3)) tick();
      chk($sformatf("lba_s%0d", s), bus.sd_lba, 32'(13 * trk + s));
      chk($sformatf("wr_req_s%0d", s), bus.sd_wr, 1);
      bus.sd_ack = 1'b1;
      bus.sd_buff_addr = 9'd0;
      bad = 0;
      first = -1;
      for (int a = 0; a < 512; a++) begin
        if (mode == 2 && s == 7 && a == 200) begin
          #2 rst = 1'b1;
          #1;
          chk("rst_wr", bus.sd_wr, 0);
          chk("rst_lba", bus.sd_lba, 0);
          chk("rst_cpu_wait", cpu_wait, 0);
          chk("rst_busy", busy, 0);
          chk("rst_load_hold", load_hold, 0);
          bus.sd_ack = 1'b0;
          tick();
          rst = 1'b0;
          tick();
          return;
        end
        if (mode == 1 && s == 4 && a == 100) img_mounted = 1'b1;
        tick();
        img_mounted = 1'b0;
        if (mode == 1 && s == 4 && a == 100)
          chk("mount_wr_drop", bus.sd_wr, 0);
        if (bus.sd_buff_din !== mem[s * 512 + a]) begin
          if (first < 0) first = a;
          bad++;
        end
        bus.sd_buff_addr = 9'(a + 1);
      end
      chk($sformatf("bytes_s%0d_first_bad%0d", s, first), bad, 0);
      chk($sformatf("lba_inc_s%0d", s), bus.sd_lba, 32'(13 * trk + s + 1));
      wexp = (s == 12 || (mode == 1 && s == 4)) ? 0 : 1;
      chk($sformatf("wr_end_s%0d", s), bus.sd_wr, wexp);
      bus.sd_ack = 1'b0;
      tick();
      if (wexp == 0) begin
        chk("done_busy", busy, 0);
        chk("done_cpu_wait", cpu_wait, 0);
        return;
      end
      chk("mid_busy", busy, 1);
      chk("mid_cpu_wait", cpu_wait, 1);
    end
  endtask

  initial begin
    int t;
    int nw;
    bit by_track;
    bus.sd_ack = 1'b0;
    bus.sd_buff_addr = 9'd0;
    fill(1'b1);
    tick();
    chk("reset_wr", bus.sd_wr, 0);
    chk("reset_lba", bus.sd_lba, 0);
    chk("reset_cpu_wait", cpu_wait, 0);
    chk("reset_busy", busy, 0);
    chk("reset_load_hold", load_hold, 0);
    rst = 1'b0;
    tick();

    // Single write on track 5, then step to 6.
    cur_track = 6'd5;
    track_req = 6'd5;
    disk_we = 1'b1;
    tick();
    disk_we = 1'b0;
    tick();
    chk("no_hold_same_track", load_hold, 0);
    track_req = 6'd6;
    #1;
    chk("hold_on_mismatch", load_hold, 1);
    chk("not_busy_yet", busy, 0);
    tick();
    host(5, 0);
    chk("hold_released", load_hold, 0);
    cur_track = 6'd6;
    tick();

    // Read-only image never becomes dirty.
    img_readonly = 1'b1;
    disk_we = 1'b1;
    tick();
    disk_we = 1'b0;
    track_req = 6'd7;
    #1;
    chk("ro_no_hold", load_hold, 0);
    repeat (120) tick();
    chk("ro_no_wr", bus.sd_wr, 0);
    chk("ro_not_busy", busy, 0);
    img_readonly = 1'b0;
    cur_track = 6'd7;
    tick();

    // Idle timeout: start 101 cycles after the last write.
    fill(1'b0);
    disk_we = 1'b1;
    tick();
    disk_we = 1'b0;
    repeat (100) tick();
    chk("tmo_not_yet_100", bus.sd_wr, 0);
    tick();
    chk("tmo_start_101", bus.sd_wr, 1);
    host(7, 0);
    disk_we = 1'b1;
    tick();
    disk_we = 1'b0;
    repeat (49) tick();
    disk_we = 1'b1;
    tick();
    disk_we = 1'b0;
    repeat (100) tick();
    chk("tmo_not_yet_150", bus.sd_wr, 0);
    tick();
    chk("tmo_start_151", bus.sd_wr, 1);
    host(7, 0);

    // Remount during sector 4.
    fill(1'b0);
    t = $urandom_range(0, 63);
    cur_track = 6'(t);
    track_req = 6'(t);
    disk_we = 1'b1;
    tick();
    disk_we = 1'b0;
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    host(t, 1);
    repeat (10) tick();
    chk("mount_no_more_wr", bus.sd_wr, 0);
    chk("mount_idle", busy, 0);
    track_req = 6'(t ^ 1);
    #1;
    chk("mount_dirty_clear", load_hold, 0);
    cur_track = track_req;
    tick();

    // Reset during sector 7, then a fresh flush from sector 0.
    t = $urandom_range(0, 63);
    cur_track = 6'(t);
    track_req = 6'(t);
    disk_we = 1'b1;
    tick();
    disk_we = 1'b0;
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    host(t, 2);
    disk_we = 1'b1;
    tick();
    disk_we = 1'b0;
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    host(t, 0);

    // Randomized writes and triggers.
    for (int r = 0; r < 2; r++) begin
      fill(1'b0);
      t = $urandom_range(0, 62);
      cur_track = 6'(t);
      track_req = 6'(t);
      tick();
      nw = $urandom_range(1, 4);
      for (int k = 0; k < nw; k++) begin
        disk_we = 1'b1;
        tick();
        disk_we = 1'b0;
        repeat ($urandom_range(0, 8)) tick();
      end
      by_track = 1'($urandom);
      if (by_track) begin
        track_req = 6'(t + 1);
        #1;
        chk("rnd_hold", load_hold, 1);
      end else begin
        flush_req = 1'b1;
      end
      tick();
      flush_req = 1'b0;
      host(t, 0);
      chk("rnd_hold_off", load_hold, 0);
      cur_track = track_req;
      tick();
    end

    repeat (5) tick();
    chk("final_idle", busy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
